sd_spi_responder: RTL

- SPI-mode SD card responder (device end) for the sdspihost initiator used by the autotest flow; lets autotest runs in simulation and on FPGA loopback boards work without a physical card.
- Decodes 6-byte SD commands on SPI mode 0 and returns R1/R3/R7 responses.
- Serves single-block reads (CMD17) and writes (CMD24) from a byte-wide synchronous memory port.
- Runs in the system clock domain by oversampling sclk.

---
 rtl/sd_spi_responder.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card device model that answers init commands and serves CMD17/CMD24 from a byte-wide memory port
module sd_spi_responder #(
  parameter int MEM_ADDR_W = 16,
  parameter int NAC_BYTES  = 2,
  parameter int BUSY_BYTES = 4,
  parameter int INIT_POLLS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  card_ready,
  output logic [5:0]            last_cmd
);
  localparam int BW = MEM_ADDR_W - 9;
  typedef enum logic [3:0] {
    S_CMD, S_NCR, S_RESP, S_TAIL, S_RD_NAC, S_RD_TOKEN, S_RD_DATA, S_RD_CRC,
    S_WR_TOKEN, S_WR_DATA, S_WR_CRC, S_WR_DRESP, S_WR_BUSY
  } state_t;
  state_t state_q, state_d;
  logic [2:0] sclk_q;
  logic [1:0] cs_q, mosi_q;
  logic [2:0] bit_q, bit_d, fcnt_q, fcnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, r1_q, r1_d, wdata_q, wdata_d, poll_q, poll_d;
  logic [8:0] idx_q, idx_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [5:0] cmd_q, cmd_d, last_cmd_q, last_cmd_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic acmd_q, acmd_d, ready_q, ready_d, miso_q, miso_d, we_q, we_d, fresh_q, fresh_d;
  logic rise, fall, byte_done, idle, hit, acmd41, is_tail;
  logic [7:0] rx_byte, r1, src, tail_b;
  logic [31:0] tail_w;
  logic [1:0] tn;
  assign rise = sclk_q[1] & ~sclk_q[2] & ~cs_q[1];
  assign fall = ~sclk_q[1] & sclk_q[2] & ~cs_q[1];
  assign byte_done = rise && bit_q == 3'd7;
  assign rx_byte = {rx_q[6:0], mosi_q[1]};
  assign idle = ~ready_q;
  assign hit = poll_q + 8'd1 == 8'(INIT_POLLS);
  assign acmd41 = acmd_q && cmd_q == 6'd41;
  assign r1 = cmd_q == 6'd0 ? 8'h01
    : (cmd_q == 6'd8 || cmd_q == 6'd16 || cmd_q == 6'd55 || cmd_q == 6'd58) ? {7'd0, idle}
    : acmd41 ? {7'd0, ~(ready_q | hit)}
    : (cmd_q == 6'd17 || cmd_q == 6'd24) ? (ready_q ? 8'h00 : 8'h05)
    : {5'd0, 1'b1, 1'b0, idle};
  assign is_tail = cmd_q == 6'd8 || cmd_q == 6'd58;
  assign tail_w = cmd_q == 6'd8 ? 32'h0000_01AA : 32'hC0FF_8000;
  assign tn = state_q == S_TAIL ? idx_q[1:0] + 2'd1 : 2'd0;
  assign tail_b = tail_w[{~tn, 3'b000} +: 8];
  assign src = fresh_q ? mem_rdata : tx_q;
  assign miso = miso_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we = we_q;
  assign card_ready = ready_q;
  assign last_cmd = last_cmd_q;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    fcnt_d = fcnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    r1_d = r1_q;
    wdata_d = wdata_q;
    poll_d = poll_q;
    idx_d = idx_q;
    blk_d = blk_q;
    cmd_d = cmd_q;
    last_cmd_d = last_cmd_q;
    addr_d = addr_q;
    acmd_d = acmd_q;
    ready_d = ready_q;
    miso_d = miso_q;
    fresh_d = fresh_q;
    we_d = 1'b0;
    if (rise) begin
      rx_d = rx_byte;
      bit_d = bit_q + 3'd1;
    end
    if (fall) begin
      miso_d = src[7];
      tx_d = {src[6:0], 1'b1};
      fresh_d = 1'b0;
    end
    if (byte_done) begin
      tx_d = 8'hFF;
      idx_d = idx_q + 9'd1;
      case (state_q)
        S_CMD: begin
          idx_d = '0;
          if (fcnt_q == 3'd0) begin
            if (rx_byte[7:6] == 2'b01) begin
              fcnt_d = 3'd1;
              cmd_d = rx_byte[5:0];
            end
          end else if (fcnt_q != 3'd5) begin
            fcnt_d = fcnt_q + 3'd1;
            blk_d = BW'({blk_q, rx_byte});
          end else begin
            fcnt_d = '0;
            last_cmd_d = cmd_q;
            r1_d = r1;
            acmd_d = cmd_q == 6'd55;
            state_d = S_NCR;
            if (cmd_q == 6'd0) begin
              ready_d = 1'b0;
              poll_d = '0;
            end
            if (acmd41) begin
              poll_d = poll_q + 8'd1;
              ready_d = ready_q | hit;
            end
          end
        end
        S_NCR: begin
          state_d = S_RESP;
          tx_d = r1_q;
        end
        S_RESP: begin
          idx_d = '0;
          state_d = is_tail ? S_TAIL
            : (ready_q && cmd_q == 6'd17) ? S_RD_NAC
            : (ready_q && cmd_q == 6'd24) ? S_WR_TOKEN : S_CMD;
          tx_d = is_tail ? tail_b : 8'hFF;
        end
        S_TAIL: begin
          state_d = idx_q == 9'd3 ? S_CMD : S_TAIL;
          tx_d = idx_q == 9'd3 ? 8'hFF : tail_b;
        end
        S_RD_NAC: if (idx_q == 9'(NAC_BYTES - 1)) begin
          state_d = S_RD_TOKEN;
          tx_d = 8'hFE;
          idx_d = '0;
        end
        S_RD_TOKEN: begin
          state_d = S_RD_DATA;
          idx_d = '0;
          addr_d = {blk_q, 9'd0};
          fresh_d = 1'b1;
        end
        S_RD_DATA: if (idx_q == 9'd511) begin
          state_d = S_RD_CRC;
          idx_d = '0;
        end else begin
          addr_d = {blk_q, idx_d};
          fresh_d = 1'b1;
        end
        S_RD_CRC: state_d = idx_q == 9'd1 ? S_CMD : S_RD_CRC;
        S_WR_TOKEN: begin
          idx_d = '0;
          state_d = rx_byte == 8'hFE ? S_WR_DATA : S_WR_TOKEN;
        end
        S_WR_DATA: begin
          we_d = 1'b1;
          addr_d = {blk_q, idx_q};
          wdata_d = rx_byte;
          if (idx_q == 9'd511) begin
            state_d = S_WR_CRC;
            idx_d = '0;
          end
        end
        S_WR_CRC: if (idx_q == 9'd1) begin
          state_d = S_WR_DRESP;
          tx_d = 8'h05;
          idx_d = '0;
        end
        S_WR_DRESP: begin
          state_d = S_WR_BUSY;
          tx_d = 8'h00;
          idx_d = '0;
        end
        S_WR_BUSY: begin
          state_d = idx_q == 9'(BUSY_BYTES - 1) ? S_CMD : S_WR_BUSY;
          tx_d = idx_q == 9'(BUSY_BYTES - 1) ? 8'hFF : 8'h00;
        end
        default: state_d = S_CMD;
      endcase
    end
    if (cs_q[1]) begin
      state_d = S_CMD;
      bit_d = '0;
      fcnt_d = '0;
      idx_d = '0;
      tx_d = 8'hFF;
      miso_d = 1'b1;
      we_d = 1'b0;
      fresh_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q <= '0;
      cs_q <= '1;
      mosi_q <= '1;
      state_q <= S_CMD;
      bit_q <= '0;
      fcnt_q <= '0;
      rx_q <= '0;
      tx_q <= 8'hFF;
      r1_q <= '0;
      wdata_q <= '0;
      poll_q <= '0;
      idx_q <= '0;
      blk_q <= '0;
      cmd_q <= '0;
      last_cmd_q <= '0;
      addr_q <= '0;
      acmd_q <= 1'b0;
      ready_q <= 1'b0;
      miso_q <= 1'b1;
      we_q <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q <= {cs_q[0], cs};
      mosi_q <= {mosi_q[0], mosi};
      state_q <= state_d;
      bit_q <= bit_d;
      fcnt_q <= fcnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      r1_q <= r1_d;
      wdata_q <= wdata_d;
      poll_q <= poll_d;
      idx_q <= idx_d;
      blk_q <= blk_d;
      cmd_q <= cmd_d;
      last_cmd_q <= last_cmd_d;
      addr_q <= addr_d;
      acmd_q <= acmd_d;
      ready_q <= ready_d;
      miso_q <= miso_d;
      we_q <= we_d;
      fresh_q <= fresh_d;
    end
  end
endmodule
